// File: rtl/pipe_hazard_ctrl_if.sv
// Stage information flowing from the Y86-64 datapath into the hazard controller,
// and the stall/bubble controls flowing back to the pipeline registers.
interface pipe_hazard_ctrl_if;
    logic [3:0] D_icode;
    logic [3:0] E_icode;
    logic [3:0] M_icode;
    logic [3:0] E_dstM;
    logic [3:0] d_srcA;
    logic [3:0] d_srcB;
    logic       e_Cnd;
    logic [3:0] m_stat;
    logic [3:0] W_stat;

    logic       F_stall;
    logic       D_stall;
    logic       W_stall;
    logic       D_bubble;
    logic       E_bubble;
    logic       M_bubble;
    logic       set_cc;
    logic       halted;

    modport master (
        output D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_Cnd, m_stat, W_stat,
        input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted
    );

    modport slave (
        input  D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_Cnd, m_stat, W_stat,
        output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: load-use/ret/mispredict hazards, exception drain and halt,
// plus saturating performance counters that freeze once the pipeline has halted.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_hazard_ctrl_if.slave pif,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] ret_cnt
);
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [3:0] S_AOK    = 4'h0;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    state_t state;
    logic   halted_q;
    logic   load_use, ret_in, mispred, exc, active;

    assign load_use = ((pif.E_icode == I_MRMOVQ) || (pif.E_icode == I_POPQ))
                      && (pif.E_dstM != R_NONE)
                      && ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
    assign ret_in   = (pif.D_icode == I_RET) || (pif.E_icode == I_RET) || (pif.M_icode == I_RET);
    assign mispred  = (pif.E_icode == I_JXX) && !pif.e_Cnd;
    assign exc      = (pif.m_stat != S_AOK) || (pif.W_stat != S_AOK);
    assign active   = (state != ST_HALTED);

    // A faulting instruction in M drains to W first; once W holds it, freeze for good.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (pif.W_stat != S_AOK) begin
                        state    <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else if (pif.m_stat != S_AOK) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pif.W_stat != S_AOK) begin
                        state    <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_HALTED;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign pif.halted = halted_q;

    always_comb begin
        // NOTE: every output is given a default first, so no branch can infer a latch.
        pif.F_stall  = 1'b0;
        pif.D_stall  = 1'b0;
        pif.W_stall  = 1'b0;
        pif.D_bubble = 1'b0;
        pif.E_bubble = 1'b0;
        pif.M_bubble = 1'b0;
        pif.set_cc   = 1'b0;
        if (!rst_n) begin
            // Held in reset: flush D/E/M to nops so the pipeline comes up clean.
            pif.D_bubble = 1'b1;
            pif.E_bubble = 1'b1;
            pif.M_bubble = 1'b1;
        end else if (state == ST_HALTED) begin
            pif.F_stall  = 1'b1;
            pif.D_stall  = 1'b1;
            pif.W_stall  = 1'b1;
            pif.E_bubble = 1'b1;
            pif.M_bubble = 1'b1;
        end else begin
            pif.F_stall  = load_use || ret_in;
            pif.D_stall  = load_use;
            pif.D_bubble = mispred || (ret_in && !load_use);
            pif.E_bubble = mispred || load_use;
            pif.M_bubble = exc;
            pif.W_stall  = (pif.W_stat != S_AOK);
            pif.set_cc   = (pif.E_icode == I_OPQ) && !exc && (state != ST_DRAIN);
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? (v + CNT_ONE) : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            lu_cnt  <= '0;
            mp_cnt  <= '0;
            ret_cnt <= '0;
        end else if (active) begin
            cyc_cnt <= sat_inc(cyc_cnt, 1'b1);
            lu_cnt  <= sat_inc(lu_cnt, load_use);
            mp_cnt  <= sat_inc(mp_cnt, mispred);
            ret_cnt <= sat_inc(ret_cnt, ret_in && !load_use);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; control outputs are viewed as one packed vector
// {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted}.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;

    localparam logic [7:0] C_IDLE  = 8'b0000_0000;
    localparam logic [7:0] C_FLUSH = 8'b0001_1100;
    localparam logic [7:0] C_LU    = 8'b1100_1000;
    localparam logic [7:0] C_MP    = 8'b0001_1000;
    localparam logic [7:0] C_RET   = 8'b1001_0000;
    localparam logic [7:0] C_MPRET = 8'b1001_1000;
    localparam logic [7:0] C_CC    = 8'b0000_0010;
    localparam logic [7:0] C_MEXC  = 8'b0000_0100;
    localparam logic [7:0] C_WEXC  = 8'b0010_0100;
    localparam logic [7:0] C_HALT  = 8'b1110_1101;

    logic clk = 1'b0;
    logic rst_n;
    logic [CNT_W-1:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;
    logic [7:0] ctl;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if pif ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pif     (pif),
        .cyc_cnt (cyc_cnt),
        .lu_cnt  (lu_cnt),
        .mp_cnt  (mp_cnt),
        .ret_cnt (ret_cnt)
    );

    assign ctl = {pif.F_stall, pif.D_stall, pif.W_stall, pif.D_bubble,
                  pif.E_bubble, pif.M_bubble, pif.set_cc, pif.halted};

    task automatic drive_idle();
        pif.D_icode = 4'h1;
        pif.E_icode = 4'h1;
        pif.M_icode = 4'h1;
        pif.E_dstM  = 4'hF;
        pif.d_srcA  = 4'hF;
        pif.d_srcB  = 4'hF;
        pif.e_Cnd   = 1'b1;
        pif.m_stat  = 4'h0;
        pif.W_stat  = 4'h0;
    endtask

    // Leaves the bench at a falling edge with rst_n just released.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        #1;
        checks++;
        if (ctl !== C_FLUSH) begin failures++; $display("FAIL reset_flush ctl=%b exp=%b", ctl, C_FLUSH); end
        checks++;
        if ({cyc_cnt, lu_cnt, mp_cnt, ret_cnt} !== '0) begin
            failures++; $display("FAIL reset_cnt cyc=%0d lu=%0d mp=%0d ret=%0d exp=0", cyc_cnt, lu_cnt, mp_cnt, ret_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin failures++; $display("FAIL reset_idle ctl=%b exp=%b", ctl, C_IDLE); end
        @(negedge clk);
        checks++;
        if (cyc_cnt !== 4'd1) begin failures++; $display("FAIL reset_first_cycle cyc=%0d exp=1", cyc_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        pif.E_icode = 4'h5; pif.E_dstM = 4'h3; pif.d_srcA = 4'h3;
        #1;
        checks++;
        if (ctl !== C_LU) begin failures++; $display("FAIL lu_srcA ctl=%b exp=%b", ctl, C_LU); end
        @(negedge clk);
        checks++;
        if (lu_cnt !== 4'd1) begin failures++; $display("FAIL lu_cnt1 lu=%0d exp=1", lu_cnt); end
        pif.d_srcA = 4'h4; pif.d_srcB = 4'hF;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin failures++; $display("FAIL lu_nomatch ctl=%b exp=%b", ctl, C_IDLE); end
        @(negedge clk);
        pif.E_icode = 4'hB; pif.E_dstM = 4'h2; pif.d_srcA = 4'hF; pif.d_srcB = 4'h2;
        #1;
        checks++;
        if (ctl !== C_LU) begin failures++; $display("FAIL lu_popq_srcB ctl=%b exp=%b", ctl, C_LU); end
        @(negedge clk);
        pif.E_icode = 4'h5; pif.E_dstM = 4'hF; pif.d_srcA = 4'hF; pif.d_srcB = 4'hF;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin failures++; $display("FAIL lu_none_reg ctl=%b exp=%b", ctl, C_IDLE); end
        @(negedge clk);
        pif.E_icode = 4'h4; pif.E_dstM = 4'h3; pif.d_srcA = 4'h3;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin failures++; $display("FAIL lu_not_load ctl=%b exp=%b", ctl, C_IDLE); end
        @(negedge clk);
        checks++;
        if ({lu_cnt, cyc_cnt} !== {4'd2, 4'd5}) begin
            failures++; $display("FAIL lu_totals lu=%0d cyc=%0d exp lu=2 cyc=5", lu_cnt, cyc_cnt);
        end
    endtask

    task automatic test_mispred();
        do_reset();
        pif.E_icode = 4'h7; pif.e_Cnd = 1'b0;
        #1;
        checks++;
        if (ctl !== C_MP) begin failures++; $display("FAIL mp_taken_wrong ctl=%b exp=%b", ctl, C_MP); end
        @(negedge clk);
        checks++;
        if (mp_cnt !== 4'd1) begin failures++; $display("FAIL mp_cnt1 mp=%0d exp=1", mp_cnt); end
        pif.e_Cnd = 1'b1;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin failures++; $display("FAIL mp_correct ctl=%b exp=%b", ctl, C_IDLE); end
        @(negedge clk);
        checks++;
        if (mp_cnt !== 4'd1) begin failures++; $display("FAIL mp_cnt_hold mp=%0d exp=1", mp_cnt); end
    endtask

    task automatic test_ret_seq();
        do_reset();
        pif.D_icode = 4'h9;
        #1;
        checks++;
        if (ctl !== C_RET) begin failures++; $display("FAIL ret_in_D ctl=%b exp=%b", ctl, C_RET); end
        @(negedge clk);
        pif.D_icode = 4'h1; pif.E_icode = 4'h9;
        #1;
        checks++;
        if (ctl !== C_RET) begin failures++; $display("FAIL ret_in_E ctl=%b exp=%b", ctl, C_RET); end
        @(negedge clk);
        pif.E_icode = 4'h1; pif.M_icode = 4'h9;
        #1;
        checks++;
        if (ctl !== C_RET) begin failures++; $display("FAIL ret_in_M ctl=%b exp=%b", ctl, C_RET); end
        @(negedge clk);
        pif.M_icode = 4'h1;
        #1;
        checks++;
        if ({ctl, ret_cnt} !== {C_IDLE, 4'd3}) begin
            failures++; $display("FAIL ret_done ctl=%b ret=%0d exp ctl=%b ret=3", ctl, ret_cnt, C_IDLE);
        end
        pif.D_icode = 4'h9; pif.E_icode = 4'h5; pif.E_dstM = 4'h3; pif.d_srcA = 4'h3;
        #1;
        checks++;
        if (ctl !== C_LU) begin failures++; $display("FAIL ret_lu_priority ctl=%b exp=%b", ctl, C_LU); end
        @(negedge clk);
        pif.D_icode = 4'h1; pif.E_icode = 4'h9; pif.E_dstM = 4'hF; pif.d_srcA = 4'hF;
        #1;
        checks++;
        if (ctl !== C_RET) begin failures++; $display("FAIL ret_after_lu ctl=%b exp=%b", ctl, C_RET); end
        @(negedge clk);
        checks++;
        if ({ret_cnt, lu_cnt} !== {4'd4, 4'd1}) begin
            failures++; $display("FAIL ret_lu_totals ret=%0d lu=%0d exp ret=4 lu=1", ret_cnt, lu_cnt);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pif.E_icode = 4'h7; pif.e_Cnd = 1'b0; pif.M_icode = 4'h9;
        #1;
        checks++;
        if (ctl !== C_MPRET) begin failures++; $display("FAIL mp_ret_M ctl=%b exp=%b", ctl, C_MPRET); end
        @(negedge clk);
        pif.M_icode = 4'h1; pif.D_icode = 4'h9;
        #1;
        checks++;
        if (ctl !== C_MPRET) begin failures++; $display("FAIL mp_ret_D ctl=%b exp=%b", ctl, C_MPRET); end
        @(negedge clk);
        checks++;
        if ({mp_cnt, ret_cnt} !== {4'd2, 4'd2}) begin
            failures++; $display("FAIL mp_ret_totals mp=%0d ret=%0d exp mp=2 ret=2", mp_cnt, ret_cnt);
        end
    endtask

    task automatic test_direct_halt();
        do_reset();
        pif.W_stat = 4'h3;
        #1;
        checks++;
        if (ctl !== C_WEXC) begin failures++; $display("FAIL dh_wstall ctl=%b exp=%b", ctl, C_WEXC); end
        @(negedge clk);
        pif.W_stat = 4'h0;
        #1;
        checks++;
        if (ctl !== C_HALT) begin failures++; $display("FAIL dh_halted ctl=%b exp=%b", ctl, C_HALT); end
    endtask

    task automatic test_exception();
        do_reset();
        pif.E_icode = 4'h6;
        #1;
        checks++;
        if (ctl !== C_CC) begin failures++; $display("FAIL exc_setcc_ok ctl=%b exp=%b", ctl, C_CC); end
        @(negedge clk);
        pif.m_stat = 4'h2;
        #1;
        checks++;
        if (ctl !== C_MEXC) begin failures++; $display("FAIL exc_m_stat ctl=%b exp=%b", ctl, C_MEXC); end
        @(negedge clk);
        pif.m_stat = 4'h0;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin failures++; $display("FAIL exc_drain_nocc ctl=%b exp=%b", ctl, C_IDLE); end
        @(negedge clk);
        pif.W_stat = 4'h2;
        #1;
        checks++;
        if (ctl !== C_WEXC) begin failures++; $display("FAIL exc_w_stall ctl=%b exp=%b", ctl, C_WEXC); end
        @(negedge clk);
        pif.W_stat = 4'h0; pif.D_icode = 4'h9; pif.E_icode = 4'h5; pif.E_dstM = 4'h3; pif.d_srcA = 4'h3;
        #1;
        checks++;
        if (ctl !== C_HALT) begin failures++; $display("FAIL exc_halted ctl=%b exp=%b", ctl, C_HALT); end
        checks++;
        if (cyc_cnt !== 4'd4) begin failures++; $display("FAIL exc_cyc cyc=%0d exp=4", cyc_cnt); end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if ({ctl, cyc_cnt, lu_cnt, mp_cnt, ret_cnt} !== {C_HALT, 4'd4, 4'd0, 4'd0, 4'd0}) begin
            failures++;
            $display("FAIL exc_frozen ctl=%b cyc=%0d lu=%0d mp=%0d ret=%0d exp ctl=%b cyc=4 others 0",
                     ctl, cyc_cnt, lu_cnt, mp_cnt, ret_cnt, C_HALT);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl !== C_FLUSH) begin failures++; $display("FAIL midrst_flush ctl=%b exp=%b", ctl, C_FLUSH); end
        checks++;
        if ({cyc_cnt, lu_cnt, mp_cnt, ret_cnt} !== '0) begin
            failures++; $display("FAIL midrst_cnt cyc=%0d lu=%0d mp=%0d ret=%0d exp=0", cyc_cnt, lu_cnt, mp_cnt, ret_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        #1;
        checks++;
        if (ctl !== C_IDLE) begin failures++; $display("FAIL midrst_run ctl=%b exp=%b", ctl, C_IDLE); end
        @(negedge clk);
        checks++;
        if (cyc_cnt !== 4'd1) begin failures++; $display("FAIL midrst_cyc cyc=%0d exp=1", cyc_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        pif.E_icode = 4'h5; pif.E_dstM = 4'h3; pif.d_srcB = 4'h3;
        repeat (15) @(negedge clk);
        checks++;
        if (lu_cnt !== 4'd15) begin failures++; $display("FAIL sat_reach lu=%0d exp=15", lu_cnt); end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if ({lu_cnt, cyc_cnt, ctl} !== {4'd15, 4'd15, C_LU}) begin
            failures++; $display("FAIL sat_hold lu=%0d cyc=%0d ctl=%b exp lu=15 cyc=15 ctl=%b", lu_cnt, cyc_cnt, ctl, C_LU);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_load_use();
        test_mispred();
        test_ret_seq();
        test_simultaneous();
        test_direct_halt();
        test_exception();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
